// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel switch debouncer with shared sample tick and edge pulses
// Optional macro DEBOUNCE_MULTI_SYNC_EN: inserts a 2-flop synchroniser on every sw bit.
module debounce_multi #(
  parameter int N_CH      = 4,
  parameter int TICK_BITS = 19,
  parameter int N_TICKS   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] db_rise,
  output logic [N_CH-1:0] db_fall,
  output logic            tick
);

  // Counter width holds 0..N_TICKS; a flip happens when the count sits at N_TICKS-1 on a tick.
  localparam int            CW   = $clog2(N_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_TICKS - 1);

  logic [TICK_BITS-1:0] tick_cnt;
  logic [N_CH-1:0]      sw_eng;
  logic [CW-1:0]        cnt_q [N_CH];
  logic [CW-1:0]        cnt_d [N_CH];
  logic [N_CH-1:0]      db_d;
  logic [N_CH-1:0]      rise_d;
  logic [N_CH-1:0]      fall_d;

`ifdef DEBOUNCE_MULTI_SYNC_EN
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  // Two-stage synchroniser so asynchronous switch inputs cannot go metastable inside the engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  assign sw_eng = sync2;
`else
  assign sw_eng = sw;
`endif

  // Free-running sample timebase; tick is registered so it pulses the cycle after the counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt + TICK_BITS'(1);
      tick     <= &tick_cnt;
    end
  end

  // Per-channel next state: agreement clears the count first, so it also cancels a flip on the final tick.
  always_comb begin
    db_d   = db;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sw_eng[i] == db[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] == LAST)) begin
        db_d[i]   = ~db[i];
        cnt_d[i]  = '0;
        rise_d[i] = ~db[i];
        fall_d[i] = db[i];
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Channel state and edge-pulse registers; pulses last exactly one cycle because rise_d/fall_d default to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db      <= '0;
      db_rise <= '0;
      db_fall <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db      <= db_d;
      db_rise <= rise_d;
      db_fall <= fall_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
